swap_mem_engine: RTL and testbench

Sequential engine that exchanges the contents of two 20-bit words in a single-port synchronous memory (register file or data RAM) on request. It is the memory-side counterpart of the combinational `swap_module`: `swap_module` crosses over two values already in hand, while this block fetches both operands, crosses them over, and writes them back. It serves the CPU's XCHG-style operations and the memory test harness.

---
 rtl/urcpu_pkg.sv | 23 ++
 rtl/swap_module.sv | 21 ++
 rtl/swap_mem_engine.sv | 140 ++++++++++++++
 tb/tb_swap_mem_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/urcpu_pkg.sv
// ---------------------------------------------------------------------------
// urcpu_pkg
// Shared definitions for the CPU memory-side helpers.
//   DEF_DATA_W   : default CPU word width (20 bits)
//   DEF_ADDR_W   : default memory address width (8 bits)
//   swap_state_t : sequencing states of swap_mem_engine
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package urcpu_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } swap_state_t;

endpackage

// File: rtl/swap_module.sv
// ---------------------------------------------------------------------------
// swap_module
// Combinational crossover of two words: out_a takes in_b, out_b takes in_a.
// Ports:
//   in_a, in_b   : operands (DATA_W)
//   out_a, out_b : crossed-over operands (DATA_W)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module swap_module #(
  parameter int DATA_W = 20
) (
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  assign out_a = in_b;
  assign out_b = in_a;

endmodule

// File: rtl/swap_mem_engine.sv
// ---------------------------------------------------------------------------
// swap_mem_engine
// Exchanges two words of a single-port synchronous memory: read A, read B,
// write B's value to A, write A's value to B, then pulse done.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   addr_a, addr_b      : locations to swap, sampled on accept
//   done                : one-cycle pulse once both writes are committed
//   mem_addr/mem_we/mem_wdata/mem_rdata : memory port (1-cycle read latency)
// Build option:
//   SWAP_SKIP_SAME_EN   : when defined, a request with addr_a == addr_b
//                         completes immediately without touching memory.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module swap_mem_engine
  import urcpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  swap_state_t       state;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_b_byp;
  logic [DATA_W-1:0] x_a;
  logic [DATA_W-1:0] x_b;
  logic              mem_we_q;
  logic              same_addr;

`ifdef SWAP_SKIP_SAME_EN
  assign same_addr = (addr_a == addr_b);
`else
  assign same_addr = 1'b0;
`endif

  // B's value arrives on mem_rdata during WR_A, the same cycle it must be
  // written to A, so it is forwarded straight from the bus in that state.
  assign op_b_byp = (state == WR_A) ? mem_rdata : op_b;

  swap_module #(
    .DATA_W (DATA_W)
  ) u_swap (
    .in_a  (op_a),
    .in_b  (op_b_byp),
    .out_a (x_a),
    .out_b (x_b)
  );

  always_comb begin
    mem_wdata = '0;
    case (state)
      WR_A:    mem_wdata = x_a;
      WR_B:    mem_wdata = x_b;
      default: mem_wdata = '0;
    endcase
  end

  // Reset suppresses a write already in flight so an abort in WR_B leaves B
  // untouched; the enable is otherwise a pure register.
  assign mem_we = mem_we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_addr  <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_a_q  <= addr_a;
            addr_b_q  <= addr_b;
            req_ready <= 1'b0;
            if (same_addr) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RD_A;
              mem_addr <= addr_a;
            end
          end
        end
        RD_A: begin
          state    <= RD_B;
          mem_addr <= addr_b_q;
        end
        RD_B: begin
          op_a     <= mem_rdata;
          state    <= WR_A;
          mem_addr <= addr_a_q;
          mem_we_q <= 1'b1;
        end
        WR_A: begin
          op_b     <= mem_rdata;
          state    <= WR_B;
          mem_addr <= addr_b_q;
        end
        WR_B: begin
          state    <= DONE;
          mem_we_q <= 1'b0;
          done     <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          mem_we_q  <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_mem_engine.sv
// ---------------------------------------------------------------------------
// tb_swap_mem_engine
// Directed table of swaps plus hand-written back-to-back, reset-abort and
// random-address sequences, against a behavioural synchronous RAM.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_swap_mem_engine;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // bench-side preload port into the RAM
  logic              tb_we;
  logic [ADDR_W-1:0] tb_addr;
  logic [DATA_W-1:0] tb_data;

  logic [DATA_W-1:0] mem     [0:255];
  logic [DATA_W-1:0] ref_mem [0:15];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  swap_mem_engine #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    int                exp_lat;
    int                exp_wr;
    logic [DATA_W-1:0] exp_ma;
    logic [DATA_W-1:0] exp_mb;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Called at a negedge with the engine idle; returns at the negedge of the
  // done cycle (lat = cycles after accept, 0 on timeout).
  task automatic run_swap(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                          input bit noise, output int lat, output int wr);
    req_valid = 1'b1; addr_a = a; addr_b = b;
    @(negedge clk);
    lat = 0; wr = 0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_we) wr++;
      if (done) begin
        lat = c;
        break;
      end
      req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      addr_a = ADDR_W'($urandom);
      addr_b = ADDR_W'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wr, cnt;
    logic [ADDR_W-1:0] ra, rb;
    logic [DATA_W-1:0] t;

    rst = 1'b1; req_valid = 1'b0; addr_a = '0; addr_b = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;

    vecs[0] = '{8'h10, 8'h20, 20'h12345, 20'hABCDE, 5, 2, 20'hABCDE, 20'h12345};
    vecs[1] = '{8'h00, 8'hFF, 20'h00000, 20'hFFFFF, 5, 2, 20'hFFFFF, 20'h00000};
    vecs[2] = '{8'h7F, 8'h80, 20'h55555, 20'hAAAAA, 5, 2, 20'hAAAAA, 20'h55555};
`ifdef SWAP_SKIP_SAME_EN
    vecs[3] = '{8'h05, 8'h05, 20'hFFFFF, 20'hFFFFF, 1, 0, 20'hFFFFF, 20'hFFFFF};
`else
    vecs[3] = '{8'h05, 8'h05, 20'hFFFFF, 20'hFFFFF, 5, 2, 20'hFFFFF, 20'hFFFFF};
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
    end

    // directed table
    foreach (vecs[i]) begin
      preload(vecs[i].a, vecs[i].da);
      if (vecs[i].a != vecs[i].b) preload(vecs[i].b, vecs[i].db);
      run_swap(vecs[i].a, vecs[i].b, 1'b0, lat, wr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_mem_a", i), 32'(mem[vecs[i].a]), 32'(vecs[i].exp_ma));
      chk($sformatf("v%0d_mem_b", i), 32'(mem[vecs[i].b]), 32'(vecs[i].exp_mb));
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), 32'(req_ready), 32'd1);
    end

    // back-to-back with req_valid held high
    preload(8'h01, 20'h00001);
    preload(8'h02, 20'h00002);
    preload(8'h03, 20'h00003);
    req_valid = 1'b1; addr_a = 8'h01; addr_b = 8'h02;
    @(negedge clk);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    chk("b2b_first_latency", 32'(lat), 32'd5);
    addr_a = 8'h02; addr_b = 8'h03;
    @(negedge clk);
    chk("b2b_ready_after_done", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b_second_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    chk("b2b_second_latency", 32'(lat), 32'd5);
    chk("b2b_mem1", 32'(mem[1]), 32'h00002);
    chk("b2b_mem2", 32'(mem[2]), 32'h00003);
    chk("b2b_mem3", 32'(mem[3]), 32'h00001);
    @(negedge clk);

    // reset while in WR_B
    preload(8'h30, 20'h11111);
    preload(8'h31, 20'h22222);
    req_valid = 1'b1; addr_a = 8'h30; addr_b = 8'h31;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_we_in_wrb", 32'(mem_we), 32'd1);
    chk("abort_addr_in_wrb", 32'(mem_addr), 32'h31);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we_dropped", 32'(mem_we), 32'd0);
    chk("abort_done_low", 32'(done), 32'd0);
    chk("abort_idle_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    chk("abort_mem_a_updated", 32'(mem[8'h30]), 32'h22222);
    chk("abort_mem_b_original", 32'(mem[8'h31]), 32'h22222);

    // random addresses/data over locations 0..15, with request noise while busy
    for (int i = 0; i < 16; i++) begin
      t = DATA_W'($urandom);
      ref_mem[i] = t;
      preload(ADDR_W'(i), t);
    end
    for (int n = 0; n < 10; n++) begin
      ra = ADDR_W'($urandom_range(0, 15));
      rb = ADDR_W'($urandom_range(0, 15));
      run_swap(ra, rb, 1'b1, lat, wr);
      chk($sformatf("rnd%0d_done_seen", n), 32'(lat != 0), 32'd1);
      t = ref_mem[ra[3:0]];
      ref_mem[ra[3:0]] = ref_mem[rb[3:0]];
      ref_mem[rb[3:0]] = t;
      chk($sformatf("rnd%0d_mem_a", n), 32'(mem[ra]), 32'(ref_mem[ra[3:0]]));
      chk($sformatf("rnd%0d_mem_b", n), 32'(mem[rb]), 32'(ref_mem[rb[3:0]]));
      @(negedge clk);
    end
    cnt = 0;
    for (int i = 0; i < 16; i++)
      if (mem[i] !== ref_mem[i]) cnt++;
    chk("rnd_full_compare", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
